// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port word RAM with byte lanes.
// Latency: grant visible one cycle after the decision; read data valid one cycle after issue.
// Backpressure: ports may only issue the cycle after their ready; unannounced requests are dropped with err.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int BURST      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           p0_addr,
    input  logic [3:0]            p0_oe,
    input  logic [3:0]            p0_we,
    input  logic [31:0]           p0_wdata,
    output logic [31:0]           p0_rdata,
    output logic                  p0_valid,
    output logic                  p0_ready,
    input  logic                  p1_req,
    input  logic [31:0]           p1_addr,
    input  logic [3:0]            p1_oe,
    input  logic [3:0]            p1_we,
    input  logic [31:0]           p1_wdata,
    output logic [31:0]           p1_rdata,
    output logic                  p1_valid,
    output logic                  p1_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_oe,
    output logic [3:0]            ram_we,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata,
    output logic [31:0]           p0_wait_cycles,
    output logic                  err
);
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1} own_t;

    own_t          g, g_nxt, io, ro;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    roff, off;
    logic [31:0]   p0_hold, p1_hold, rd_shift;
    logic          p0_act, p1_act, p0_acc, p1_acc, acc;
    logic [31:0]   sel_addr, sel_wdata;
    logic [3:0]    sel_oe, sel_we, we_sh;

    // Grant state register: who may issue next cycle, and how long port 1 has held it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            g   <= OWN_NONE;
            cnt <= '0;
        end else begin
            g   <= g_nxt;
            cnt <= cnt_nxt;
        end
    end

    // Grant next-state: port 1 wins while it asks and has burst budget left, else port 0 gets a slot.
    always_comb begin
        if (p1_req && (cnt < CW'(BURST))) begin
            g_nxt   = OWN_P1;
            cnt_nxt = cnt + 1'b1;
        end else begin
            g_nxt   = OWN_P0;
            cnt_nxt = '0;
        end
    end

    // Grant outputs: ready tells a port it owns the issue slot of the following cycle.
    always_comb begin
        p0_ready = rst && (g == OWN_P0);
        p1_ready = rst && (g == OWN_P1);
    end

    // Accept the issue-slot owner's request, flag the other one, and lane-align it onto the RAM.
    always_comb begin
        p0_act = (p0_oe != 4'd0) || (p0_we != 4'd0);
        p1_act = (p1_oe != 4'd0) || (p1_we != 4'd0);
        p0_acc = rst && (io == OWN_P0) && p0_act;
        p1_acc = rst && (io == OWN_P1) && p1_act;
        acc    = p0_acc || p1_acc;
        err    = rst && ((p0_act && !p0_acc) || (p1_act && !p1_acc));
        if (p1_acc) begin
            sel_addr  = p1_addr;
            sel_oe    = p1_oe;
            sel_we    = p1_we;
            sel_wdata = p1_wdata;
        end else begin
            sel_addr  = p0_addr;
            sel_oe    = p0_oe;
            sel_we    = p0_we;
            sel_wdata = p0_wdata;
        end
        off       = sel_addr[1:0];
        // lanes pushed past byte 3 fall off the 4-bit result on purpose
        we_sh     = sel_we << off;
        ram_addr  = acc ? sel_addr[ADDR_WIDTH+1:2] : '0;
        ram_we    = acc ? we_sh : 4'd0;
        ram_wdata = acc ? (sel_wdata << {off, 3'b000}) : 32'd0;
        // a request carrying both masks is treated purely as a write
        ram_oe    = acc && (sel_oe != 4'd0) && (sel_we == 4'd0);
    end

    // Issue/read ownership tracking: remember who owns the slot and whose read is in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            io   <= OWN_NONE;
            ro   <= OWN_NONE;
            roff <= 2'd0;
        end else begin
            io <= g;
            if (ram_oe) begin
                ro   <= p1_acc ? OWN_P1 : OWN_P0;
                roff <= off;
            end else begin
                ro <= OWN_NONE;
            end
        end
    end

    // Read return: right-justify the RAM word to the reader, otherwise show the last returned value.
    always_comb begin
        rd_shift = ram_rdata >> {roff, 3'b000};
        p0_valid = rst && (ro == OWN_P0);
        p1_valid = rst && (ro == OWN_P1);
        p0_rdata = p0_valid ? rd_shift : p0_hold;
        p1_rdata = p1_valid ? rd_shift : p1_hold;
    end

    // Held read data per port, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            p0_hold <= 32'd0;
            p1_hold <= 32'd0;
        end else begin
            if (p0_valid) p0_hold <= rd_shift;
            if (p1_valid) p1_hold <= rd_shift;
        end
    end

    // Port 0 starvation counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            p0_wait_cycles <= 32'd0;
        end else if (!p0_ready) begin
            p0_wait_cycles <= p0_wait_cycles + 32'd1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-level memory model plus grant-history model checked every cycle.
// Latency: expectations for a read are captured at issue and compared one cycle later.
// Backpressure: stimulus only issues after observing ready, except where drops are exercised.
module tb_mem_arbiter;
    localparam int BURST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] p0_addr, p0_wdata, p0_rdata, p1_addr, p1_wdata, p1_rdata;
    logic [3:0]  p0_oe, p0_we, p1_oe, p1_we;
    logic        p0_valid, p0_ready, p1_valid, p1_ready, p1_req;
    logic [13:0] ram_addr;
    logic        ram_oe, err;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata, ram_rdata, p0_wait_cycles;

    int total = 0;
    int bad   = 0;
    logic en  = 1'b0;

    mem_arbiter #(.ADDR_WIDTH(14), .BURST(BURST)) dut (
        .clk(clk), .rst(rst),
        .p0_addr(p0_addr), .p0_oe(p0_oe), .p0_we(p0_we), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_valid(p0_valid), .p0_ready(p0_ready),
        .p1_req(p1_req),
        .p1_addr(p1_addr), .p1_oe(p1_oe), .p1_we(p1_we), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_valid(p1_valid), .p1_ready(p1_ready),
        .ram_addr(ram_addr), .ram_oe(ram_oe), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .p0_wait_cycles(p0_wait_cycles), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int b);
        return 8'(b) ^ 8'h5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // RAM stand-in: word array with byte enables, one-cycle read latency.
    logic [31:0] mem [0:255];
    logic        mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int w = 0; w < 256; w++)
                mem[w] <= {pat(4*w+3), pat(4*w+2), pat(4*w+1), pat(4*w)};
            mem_init <= 1'b1;
        end else begin
            if (ram_oe) ram_rdata <= mem[ram_addr[7:0]];
            for (int i = 0; i < 4; i++)
                if (ram_we[i]) mem[ram_addr[7:0]][8*i +: 8] <= ram_wdata[8*i +: 8];
        end
    end

    // Reference model: byte-addressed memory, grant history, pending read per owner.
    logic [7:0]  bm [0:1023];
    logic        bm_init = 1'b0;
    int          hist[$];
    int          m_g = 0, m_io = 0, m_pend = 0;
    logic [31:0] m_pdata = 0, m_h0 = 0, m_h1 = 0, m_wait = 0;

    always @(negedge clk) begin : cmp
        logic        a0, a1, acc0, acc1, e_err, e_oe, e_v0, e_v1, e_r0rdy, e_r1rdy;
        logic [3:0]  e_we, s_oe, s_we;
        logic [31:0] s_addr, s_wd, e_wd, e_r0, e_r1, nd;
        int          o, base, trail;
        if (!bm_init) begin
            for (int b = 0; b < 1024; b++) bm[b] = pat(b);
            bm_init = 1'b1;
        end
        a0   = (p0_oe != 4'd0) || (p0_we != 4'd0);
        a1   = (p1_oe != 4'd0) || (p1_we != 4'd0);
        acc0 = rst && (m_io == 1) && a0;
        acc1 = rst && (m_io == 2) && a1;
        e_err = rst && ((a0 && !acc0) || (a1 && !acc1));
        s_addr = acc1 ? p1_addr : p0_addr;
        s_oe   = acc1 ? p1_oe : p0_oe;
        s_we   = acc1 ? p1_we : p0_we;
        s_wd   = acc1 ? p1_wdata : p0_wdata;
        o    = int'(s_addr[1:0]);
        base = int'({s_addr[9:2], 2'b00});
        e_we = 4'd0;
        e_wd = 32'd0;
        if (acc0 || acc1)
            for (int i = 0; i < 4; i++)
                if (o + i < 4) begin
                    e_wd[8*(o+i) +: 8] = s_wd[8*i +: 8];
                    if (s_we[i]) e_we[o+i] = 1'b1;
                end
        e_oe    = (acc0 || acc1) && (s_oe != 4'd0) && (s_we == 4'd0);
        e_r0rdy = rst && (m_g == 1);
        e_r1rdy = rst && (m_g == 2);
        e_v0 = rst && (m_pend == 1);
        e_v1 = rst && (m_pend == 2);
        e_r0 = e_v0 ? m_pdata : m_h0;
        e_r1 = e_v1 ? m_pdata : m_h1;
        if (en) begin
            chk("p0_ready", 32'(p0_ready), 32'(e_r0rdy));
            chk("p1_ready", 32'(p1_ready), 32'(e_r1rdy));
            chk("err", 32'(err), 32'(e_err));
            chk("ram_oe", 32'(ram_oe), 32'(e_oe));
            chk("ram_we", 32'(ram_we), 32'(e_we));
            if (acc0 || acc1) begin
                chk("ram_addr", 32'(ram_addr), (s_addr >> 2) & 32'h3FFF);
                if (s_we != 4'd0) chk("ram_wdata", ram_wdata, e_wd);
            end
            chk("p0_valid", 32'(p0_valid), 32'(e_v0));
            chk("p1_valid", 32'(p1_valid), 32'(e_v1));
            chk("p0_rdata", p0_rdata, e_r0);
            chk("p1_rdata", p1_rdata, e_r1);
            chk("p0_wait", p0_wait_cycles, m_wait);
        end
        if (!rst) begin
            m_g = 0; m_io = 0; m_pend = 0;
            m_h0 = 0; m_h1 = 0; m_wait = 0;
            hist.delete();
        end else begin
            if (e_v0) m_h0 = m_pdata;
            if (e_v1) m_h1 = m_pdata;
            if (!e_r0rdy) m_wait = m_wait + 32'd1;
            if (e_oe) begin
                nd = 32'd0;
                for (int i = 0; i < 4 - o; i++) nd[8*i +: 8] = bm[base + o + i];
                m_pdata = nd;
                m_pend  = acc1 ? 2 : 1;
            end else begin
                m_pend = 0;
            end
            if ((acc0 || acc1) && s_we != 4'd0)
                for (int i = 0; i < 4; i++)
                    if (s_we[i] && o + i < 4) bm[base + o + i] = s_wd[8*i +: 8];
            m_io  = m_g;
            trail = 0;
            for (int i = hist.size() - 1; i >= 0; i--) begin
                if (hist[i] != 2) break;
                trail++;
            end
            m_g = (p1_req && trail < BURST) ? 2 : 1;
            hist.push_back(m_g);
            if (hist.size() > 8) void'(hist.pop_front());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic [31:0] a, input logic [3:0] oe, input logic [3:0] we, input logic [31:0] d);
        p0_addr = a; p0_oe = oe; p0_we = we; p0_wdata = d;
    endtask

    task automatic drv1(input logic [31:0] a, input logic [3:0] oe, input logic [3:0] we, input logic [31:0] d);
        p1_addr = a; p1_oe = oe; p1_we = we; p1_wdata = d;
    endtask

    initial begin
        logic [31:0] w0;
        logic        r0, r1;
        int          n1;
        rst = 1'b0; p1_req = 1'b0;
        drv0(0, 0, 0, 0); drv1(0, 0, 0, 0);
        repeat (2) cyc();
        en = 1'b1;
        cyc();
        rst = 1'b1;                                   // cycle 1 after release
        @(negedge clk);
        chk("rel_p0_rdy_c1", 32'(p0_ready), 32'd0);
        chk("rel_p1_rdy_c1", 32'(p1_ready), 32'd0);
        cyc();                                        // cycle 2
        @(negedge clk);
        chk("rel_p0_rdy_c2", 32'(p0_ready), 32'd1);
        chk("rel_wait_c2", p0_wait_cycles, 32'd1);
        cyc(); drv0(32'h103, 4'h0, 4'h1, 32'hAB);     // SB
        @(negedge clk);
        chk("sb_addr", 32'(ram_addr), 32'h40);
        chk("sb_we", 32'(ram_we), 32'h8);
        chk("sb_wdata", ram_wdata, 32'hAB000000);
        cyc(); drv0(32'h103, 4'h1, 4'h0, 0);          // LBU
        cyc(); drv0(0, 0, 0, 0);
        @(negedge clk);
        chk("lbu_valid", 32'(p0_valid), 32'd1);
        chk("lbu_rdata", p0_rdata, 32'h000000AB);
        cyc(); drv0(32'h3, 4'h0, 4'h3, 32'h1234);     // SH straddling the word end
        @(negedge clk);
        chk("sh3_we", 32'(ram_we), 32'h8);
        chk("sh3_wdata", ram_wdata, 32'h34000000);
        chk("sh3_err", 32'(err), 32'd0);
        cyc(); drv0(32'h10, 4'h0, 4'hF, 32'h11223344);
        cyc(); drv0(32'h12, 4'h3, 4'h0, 0);
        cyc(); drv0(32'h100, 4'hF, 4'h0, 0);
        @(negedge clk);
        chk("lh_rdata", p0_rdata, 32'h00001122);
        cyc(); drv0(32'h20, 4'hF, 4'hF, 32'hCAFEF00D); // write with oe set
        @(negedge clk);
        chk("wr_oe_ram_oe", 32'(ram_oe), 32'd0);
        cyc(); drv0(0, 0, 0, 0);
        @(negedge clk);
        chk("lw100_rdata", p0_rdata, 32'hAB585B5A);
        cyc();
        @(negedge clk);
        chk("wr_oe_novalid", 32'(p0_valid), 32'd0);
        cyc(); p1_req = 1'b1; drv0(32'h20, 4'hF, 4'h0, 0); // LW as grant moves to port 1
        cyc(); drv0(0, 0, 0, 0);
        @(negedge clk);
        chk("sw_p0_valid", 32'(p0_valid), 32'd1);
        chk("sw_p0_rdata", p0_rdata, 32'hCAFEF00D);
        chk("sw_p1_rdy", 32'(p1_ready), 32'd1);
        cyc(); drv1(32'h20, 4'hF, 4'h0, 0);
        cyc(); drv1(0, 0, 0, 0);
        @(negedge clk);
        chk("sw_p1_valid", 32'(p1_valid), 32'd1);
        chk("sw_p1_rdata", p1_rdata, 32'hCAFEF00D);
        chk("sw_p0_novalid", 32'(p0_valid), 32'd0);
        w0 = p0_wait_cycles;
        n1 = 0;
        for (int k = 0; k < 10; k++) begin
            r1 = p1_ready;
            r0 = p0_ready;
            n1 += int'(r1);
            cyc();
            if (r1) begin
                if (k % 2 == 0) drv1(32'h200 + 32'(4*k), 4'h0, 4'hF, 32'h10000000 + 32'(k));
                else            drv1(32'h200 + 32'(4*(k-1)) + 32'd1, 4'h1, 4'h0, 0);
            end else begin
                drv1(0, 0, 0, 0);
            end
            if (r0) drv0(32'h11, 4'h3, 4'h0, 0);
            else    drv0(0, 0, 0, 0);
        end
        chk("burst_p1_rdy", 32'(n1), 32'd8);
        chk("burst_wait", p0_wait_cycles - w0, 32'd8);
        p1_req = 1'b0;
        cyc(); drv0(0, 0, 0, 0); drv1(0, 0, 0, 0);
        repeat (2) cyc();
        cyc(); drv1(32'h20, 4'hF, 4'h0, 0);           // unannounced port-1 read
        @(negedge clk);
        chk("drop_err", 32'(err), 32'd1);
        chk("drop_oe", 32'(ram_oe), 32'd0);
        chk("drop_we", 32'(ram_we), 32'd0);
        cyc(); drv1(0, 0, 0, 0);
        @(negedge clk);
        chk("drop_novalid", 32'(p1_valid), 32'd0);
        cyc(); drv1(32'h300, 4'h0, 4'hF, 32'hFFFFFFFF); // unannounced write must not land
        cyc(); drv1(0, 0, 0, 0); drv0(32'h300, 4'hF, 4'h0, 0);
        cyc(); drv0(0, 0, 0, 0);
        @(negedge clk);
        chk("drop_wr_kept", p0_rdata, 32'h59585B5A);
        cyc(); drv0(32'h10, 4'hF, 4'h0, 0);
        cyc(); rst = 1'b0; drv0(0, 0, 0, 0);          // reset while the read is in flight
        @(negedge clk);
        chk("rst_mid_valid", 32'(p0_valid), 32'd0);
        cyc();
        @(negedge clk);
        chk("rst_rdata", p0_rdata, 32'd0);
        chk("rst_wait", p0_wait_cycles, 32'd0);
        cyc(); rst = 1'b1;
        repeat (6) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
